// File: rtl/systolic_sequencer.sv
// systolic_sequencer: runs one 2x2 weight-stationary matrix job on the systolic array.
// Captures W and A on an accepted start. It then drives the array through an optional
// weight load, a skewed three-cycle activation feed and a zero-fill drain. Column
// accumulator outputs are sampled into r00..r11 at fixed cycles, and done pulses.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   start, reload_w       job request (IDLE only); reload_w=1 loads new weights first
//   abort                 cancel a running job (LOAD/FEED/DRAIN)
//   w00..w11, a00..a11    weight / activation matrices, captured on accepted start
//   busy, done            job in progress / one-cycle results-valid pulse
//   r00..r11              result matrix, held until the next accepted start
//   load_weight, valid    array control
//   a_in1, a_in2          array row 0 / row 1 activations
//   weight1..weight4      array PE weights (w00, w01, w10, w11)
//   acc_out1, acc_out2    array column 0 / column 1 accumulator outputs
`timescale 1ns/1ps
module systolic_sequencer #(
    parameter int unsigned DW  = 16,
    parameter int unsigned AW  = 32,
    parameter int unsigned LAT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          reload_w,
    input  logic          abort,
    input  logic [DW-1:0] w00,
    input  logic [DW-1:0] w01,
    input  logic [DW-1:0] w10,
    input  logic [DW-1:0] w11,
    input  logic [DW-1:0] a00,
    input  logic [DW-1:0] a01,
    input  logic [DW-1:0] a10,
    input  logic [DW-1:0] a11,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] r00,
    output logic [AW-1:0] r01,
    output logic [AW-1:0] r10,
    output logic [AW-1:0] r11,
    output logic          load_weight,
    output logic          valid,
    output logic [DW-1:0] a_in1,
    output logic [DW-1:0] a_in2,
    output logic [DW-1:0] weight1,
    output logic [DW-1:0] weight2,
    output logic [DW-1:0] weight3,
    output logic [DW-1:0] weight4,
    input  logic [AW-1:0] acc_out1,
    input  logic [AW-1:0] acc_out2
);

    // k must reach LAT+2
    localparam int unsigned KW = $clog2(LAT + 3);
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_CAP0 = KW'(LAT);
    localparam logic [KW-1:0] K_CAP1 = KW'(LAT + 1);
    localparam logic [KW-1:0] K_CAP2 = KW'(LAT + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [DW-1:0] a00_q, a01_q, a10_q, a11_q;

    // Sequencer: state, feed counter and every registered output.
    // Outputs are computed from the state being entered, so they line up
    // with that state's cycle. weight1..4 double as the captured W.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            k           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_weight <= 1'b0;
            valid       <= 1'b0;
            a_in1       <= '0;
            a_in2       <= '0;
            weight1     <= '0;
            weight2     <= '0;
            weight3     <= '0;
            weight4     <= '0;
            a00_q       <= '0;
            a01_q       <= '0;
            a10_q       <= '0;
            a11_q       <= '0;
            r00         <= '0;
            r01         <= '0;
            r10         <= '0;
            r11         <= '0;
        end else begin
            done        <= 1'b0;
            load_weight <= 1'b0;
            valid       <= 1'b0;
            a_in1       <= '0;
            a_in2       <= '0;

            // Column results emerge at k = LAT + t + j for result row t, column j
            if (state == S_DRAIN) begin
                if (k == K_CAP0) begin
                    r00 <= acc_out1;
                end
                if (k == K_CAP1) begin
                    r10 <= acc_out1;
                    r01 <= acc_out2;
                end
                if (k == K_CAP2) begin
                    r11 <= acc_out2;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        weight1 <= w00;
                        weight2 <= w01;
                        weight3 <= w10;
                        weight4 <= w11;
                        a00_q   <= a00;
                        a01_q   <= a01;
                        a10_q   <= a10;
                        a11_q   <= a11;
                        r00     <= '0;
                        r01     <= '0;
                        r10     <= '0;
                        r11     <= '0;
                        busy    <= 1'b1;
                        k       <= '0;
                        if (reload_w) begin
                            state       <= S_LOAD;
                            load_weight <= 1'b1;
                        end else begin
                            // skip LOAD: enter FEED k=0 directly from the live inputs
                            state <= S_FEED;
                            valid <= 1'b1;
                            a_in1 <= a00;
                        end
                    end
                end

                S_LOAD: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_FEED;
                        valid <= 1'b1;
                        a_in1 <= a00_q;
                    end
                end

                // Skewed feed: row 1 lags row 0 by one cycle
                S_FEED: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        k     <= k + K_ONE;
                        valid <= 1'b1;
                        if (k == '0) begin
                            a_in1 <= a01_q;
                            a_in2 <= a10_q;
                        end else if (k == K_ONE) begin
                            a_in2 <= a11_q;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (k == K_CAP2) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        k     <= k + K_ONE;
                        valid <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    k     <= '0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Controller that runs one complete 2x2 matrix job on the weight-stationary systolic array (`top_level_module`) without host micro-management. It captures a weight matrix W and an activation matrix A, then drives the array's pins cycle by cycle:
- one `load_weight` cycle, optionally skipped;
- a skewed three-cycle activation feed;
- a zero-fill drain.

It samples the column accumulator outputs at fixed cycles into a 2x2 result register and pulses `done`. It sits between the host/command logic and the array.

## Interface
- DW, 16, activation/weight width
- AW, 32, accumulator/result width
- LAT, 3, cycles from feed cycle k=0 until acc_out1 shows result r00 (min 3)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- start  in  1  job request, sampled only in IDLE
- reload_w  in  1  with start: 1 = load new weights, 0 = reuse weights already in array
- abort  in  1  cancel running job
- w00,w01,w10,w11  in  DW each  weight matrix W[i][j], captured on accepted start
- a00,a01,a10,a11  in  DW each  activation matrix A[i][j], captured on accepted start
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse, results valid
- r00,r01,r10,r11  out  AW each  result matrix, held until the next accepted start
- load_weight  out  1  to array
- valid  out  1  to array
- a_in1,a_in2  out  DW each  to array row 0 / row 1
- weight1..weight4  out  DW each  to array PE(0,0),(0,1),(1,0),(1,1) = w00,w01,w10,w11
- acc_out1,acc_out2  in  AW each  array column 0 / column 1 outputs

## Operation
- States: IDLE, LOAD, FEED, DRAIN, DONE.
- Counter k counts cycles from the first FEED cycle (k=0). Its width must hold LAT+2.
- **IDLE.** Outputs are idle: `load_weight`=0, `valid`=0, `a_in*`=0. On start=1, capture W and A and clear r*.
  - reload_w=1 → LOAD.
  - reload_w=0 → FEED.
- **LOAD** (1 cycle). `load_weight`=1 and `weight1..4` driven from the captured W. Next state is FEED.
- `weight1..4` hold the last captured W in all states.
- **FEED** (k=0..2). `valid`=1.
  - k=0: a_in1=a00, a_in2=0.
  - k=1: a_in1=a01, a_in2=a10.
  - k=2: a_in1=0, a_in2=a11.
- **DRAIN** (k=3..LAT+2). `valid`=1 and a_in1=a_in2=0.
- **Capture.** The sequencer registers acc values at the end of the cycle named:
  - k=LAT: r00 ← acc_out1.
  - k=LAT+1: r10 ← acc_out1 and r01 ← acc_out2.
  - k=LAT+2: r11 ← acc_out2.
- **DONE** (1 cycle). `done`=1, `valid`=0. Next state is IDLE.
- **Arithmetic.** The block computes nothing. Results are the array's sums: r[t][j] = A[0][t]·W[0][j] + A[1][t]·W[1][j], i.e. Aᵀ·W, with AW-bit wrap done in the array.
- **abort=1** in LOAD, FEED or DRAIN: next state is IDLE and array drive outputs go to 0. There is no done pulse and r* keep their partial/cleared contents. abort in IDLE or DONE is ignored; DONE still pulses.
- **start outside IDLE** is ignored. start and abort high together in IDLE: start wins and abort is ignored.
- **start in the cycle DONE is high** is not accepted. The earliest next accept is the following IDLE cycle.

## Timing
- Reset (reset=0 at a clock edge), in any state: IDLE, k=0. All outputs 0, including r*, weight1..4 and captured W/A.
- Reset takes precedence over start and abort.
- Let E be the edge where start is accepted.
  - reload_w=1: LOAD is the cycle after E, FEED k=0 is two cycles after E, and `done` is high LAT+5 cycles after E.
  - reload_w=0: every state is one cycle earlier, so `done` is high LAT+4 cycles after E.
- `busy` rises with the first post-E cycle and falls the cycle after DONE.
- Back-to-back jobs: minimum period is LAT+6 cycles with reload, or LAT+5 without.

## Test plan
1. **Basic job.** W=[[3,5],[4,6]], A=[[11,12],[21,22]], reload_w=1, LAT=3, against a bench array model with the same latency.
   - load_weight is high exactly 1 cycle.
   - a_in1/a_in2 sequence is 11/0, 12/21, 0/22.
   - done pulses 8 cycles after the accepting edge.
   - r00=117, r01=181, r10=124, r11=192.
2. **Weight reuse.** Repeat with A=[[1,0],[0,1]] and reload_w=0.
   - No load_weight pulse.
   - r00=3, r01=5, r10=4, r11=6.
   - done pulses 7 cycles after the accepting edge.
3. **Abort.** Assert abort at k=1.
   - Next cycle is IDLE, valid=0, a_in*=0.
   - done never pulses and busy falls.
   - A following start completes normally with correct results.
4. **Start while busy.** Pulse start during FEED, and again during DONE.
   - Both are ignored: a single done pulse and unchanged results.
   - A start one cycle after DONE is accepted.
5. **Mid-job reset.** Drive reset=0 during DRAIN.
   - The next cycle has all outputs 0 and state IDLE.
   - Also drive reset=0 together with start: start is not accepted.
6. **Overflow/extremes.** W all 16'hFFFF, A all 16'hFFFF.
   - r* equal the model's wrapped 32-bit sums.
   - Rerun with LAT=5 and verify that the capture cycles shift accordingly.
